// File: rtl/wb_arb_if.sv
// rtl/wb_arb_if.sv - writeback arbiter bus bundle
// Groups both pipe result handshakes and the register-file / retire outputs.
//   ip_wb_*  : integer-pipe result (valid/ready + dst, result, pc, wb_en)
//   lsp_wb_* : load-store-pipe result (valid/ready + dst, result, pc, wb_en)
//   rf_wr_*  : registered register-file write port
//   wb_retire_valid / wb_retire_pc : registered retire strobe and PC
// Modports: master = producer/observer side, slave = arbiter side.
interface wb_arb_if;
    logic        ip_wb_valid;
    logic        ip_wb_ready;
    logic [4:0]  ip_wb_dst;
    logic [63:0] ip_wb_result;
    logic [63:0] ip_wb_pc;
    logic        ip_wb_wb_en;

    logic        lsp_wb_valid;
    logic        lsp_wb_ready;
    logic [4:0]  lsp_wb_dst;
    logic [63:0] lsp_wb_result;
    logic [63:0] lsp_wb_pc;
    logic        lsp_wb_wb_en;

    logic        rf_wr_en;
    logic [4:0]  rf_wr_dst;
    logic [63:0] rf_wr_data;
    logic        wb_retire_valid;
    logic [63:0] wb_retire_pc;

    modport master (
        output ip_wb_valid, ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en,
        output lsp_wb_valid, lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en,
        input  ip_wb_ready, lsp_wb_ready,
        input  rf_wr_en, rf_wr_dst, rf_wr_data, wb_retire_valid, wb_retire_pc
    );

    modport slave (
        input  ip_wb_valid, ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en,
        input  lsp_wb_valid, lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en,
        output ip_wb_ready, lsp_wb_ready,
        output rf_wr_en, rf_wr_dst, rf_wr_data, wb_retire_valid, wb_retire_pc
    );
endinterface

// File: rtl/wb_arb.sv
// rtl/wb_arb.sv - two-port writeback arbiter with round-robin grant
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wb_arb_if.slave (pipe result handshakes, rf write port, retire)
//   wb_retired_count : 64-bit retire counter, present only with WB_ARB_PERF_EN
// Each pipe owns a one-entry slot; a combinational arbiter grants one slot
// per cycle and the granted entry appears on the registered outputs next edge.
module wb_arb (
    input  logic    clk,
    input  logic    rst_n,
    wb_arb_if.slave bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [63:0] wb_retired_count
`endif
);

    logic        ip_v_q, ip_v_d;
    logic [4:0]  ip_dst_q, ip_dst_d;
    logic [63:0] ip_res_q, ip_res_d;
    logic [63:0] ip_pc_q, ip_pc_d;
    logic        ip_en_q, ip_en_d;

    logic        lsp_v_q, lsp_v_d;
    logic [4:0]  lsp_dst_q, lsp_dst_d;
    logic [63:0] lsp_res_q, lsp_res_d;
    logic [63:0] lsp_pc_q, lsp_pc_d;
    logic        lsp_en_q, lsp_en_d;

    // 1 = load-store pipe won the most recent two-way contention.
    logic        last_lsp_q, last_lsp_d;

    logic        rf_en_q, rf_en_d;
    logic [4:0]  rf_dst_q, rf_dst_d;
    logic [63:0] rf_data_q, rf_data_d;
    logic        ret_v_q, ret_v_d;
    logic [63:0] ret_pc_q, ret_pc_d;

    logic        gnt_ip, gnt_lsp;
    logic        ip_take, lsp_take;

    assign gnt_ip  = ip_v_q  && (!lsp_v_q || last_lsp_q);
    assign gnt_lsp = lsp_v_q && (!ip_v_q  || !last_lsp_q);

    // Ready depends only on slot state, never on the incoming valid.
    // rst_n gating keeps ready low while slots are held empty by reset.
    assign bus.ip_wb_ready  = rst_n && (!ip_v_q  || gnt_ip);
    assign bus.lsp_wb_ready = rst_n && (!lsp_v_q || gnt_lsp);

    assign ip_take  = bus.ip_wb_valid  && bus.ip_wb_ready;
    assign lsp_take = bus.lsp_wb_valid && bus.lsp_wb_ready;

    always_comb begin
        ip_v_d     = ip_v_q;
        ip_dst_d   = ip_dst_q;
        ip_res_d   = ip_res_q;
        ip_pc_d    = ip_pc_q;
        ip_en_d    = ip_en_q;
        lsp_v_d    = lsp_v_q;
        lsp_dst_d  = lsp_dst_q;
        lsp_res_d  = lsp_res_q;
        lsp_pc_d   = lsp_pc_q;
        lsp_en_d   = lsp_en_q;
        last_lsp_d = last_lsp_q;
        rf_en_d    = 1'b0;
        rf_dst_d   = rf_dst_q;
        rf_data_d  = rf_data_q;
        ret_v_d    = 1'b0;
        ret_pc_d   = ret_pc_q;

        // A refill in the grant cycle overrides the drain.
        if (gnt_ip) ip_v_d = 1'b0;
        if (ip_take) begin
            ip_v_d   = 1'b1;
            ip_dst_d = bus.ip_wb_dst;
            ip_res_d = bus.ip_wb_result;
            ip_pc_d  = bus.ip_wb_pc;
            ip_en_d  = bus.ip_wb_wb_en;
        end
        if (gnt_lsp) lsp_v_d = 1'b0;
        if (lsp_take) begin
            lsp_v_d   = 1'b1;
            lsp_dst_d = bus.lsp_wb_dst;
            lsp_res_d = bus.lsp_wb_result;
            lsp_pc_d  = bus.lsp_wb_pc;
            lsp_en_d  = bus.lsp_wb_wb_en;
        end

        if (ip_v_q && lsp_v_q) last_lsp_d = gnt_lsp;

        if (gnt_ip) begin
            ret_v_d   = 1'b1;
            ret_pc_d  = ip_pc_q;
            rf_dst_d  = ip_dst_q;
            rf_data_d = ip_res_q;
            rf_en_d   = ip_en_q && (ip_dst_q != 5'd0);
        end else if (gnt_lsp) begin
            ret_v_d   = 1'b1;
            ret_pc_d  = lsp_pc_q;
            rf_dst_d  = lsp_dst_q;
            rf_data_d = lsp_res_q;
            rf_en_d   = lsp_en_q && (lsp_dst_q != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_v_q     <= 1'b0;
            ip_dst_q   <= '0;
            ip_res_q   <= '0;
            ip_pc_q    <= '0;
            ip_en_q    <= 1'b0;
            lsp_v_q    <= 1'b0;
            lsp_dst_q  <= '0;
            lsp_res_q  <= '0;
            lsp_pc_q   <= '0;
            lsp_en_q   <= 1'b0;
            last_lsp_q <= 1'b0;
            rf_en_q    <= 1'b0;
            rf_dst_q   <= '0;
            rf_data_q  <= '0;
            ret_v_q    <= 1'b0;
            ret_pc_q   <= '0;
        end else begin
            ip_v_q     <= ip_v_d;
            ip_dst_q   <= ip_dst_d;
            ip_res_q   <= ip_res_d;
            ip_pc_q    <= ip_pc_d;
            ip_en_q    <= ip_en_d;
            lsp_v_q    <= lsp_v_d;
            lsp_dst_q  <= lsp_dst_d;
            lsp_res_q  <= lsp_res_d;
            lsp_pc_q   <= lsp_pc_d;
            lsp_en_q   <= lsp_en_d;
            last_lsp_q <= last_lsp_d;
            rf_en_q    <= rf_en_d;
            rf_dst_q   <= rf_dst_d;
            rf_data_q  <= rf_data_d;
            ret_v_q    <= ret_v_d;
            ret_pc_q   <= ret_pc_d;
        end
    end

    assign bus.rf_wr_en        = rf_en_q;
    assign bus.rf_wr_dst       = rf_dst_q;
    assign bus.rf_wr_data      = rf_data_q;
    assign bus.wb_retire_valid = ret_v_q;
    assign bus.wb_retire_pc    = ret_pc_q;

`ifdef WB_ARB_PERF_EN
    logic [63:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (ret_v_q) retired_cnt_d = retired_cnt_q + 64'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt_q <= '0;
        else        retired_cnt_q <= retired_cnt_d;
    end

    assign wb_retired_count = retired_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// tb/tb_wb_arb.sv - scoreboard bench for wb_arb
module tb_wb_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    wb_arb_if bus();

`ifdef WB_ARB_PERF_EN
    logic [63:0] cnt;
    wb_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus), .wb_retired_count(cnt));
`else
    wb_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    localparam logic [63:0] LTAG = 64'h0001_0000_0000_0000;

    typedef struct {
        logic [4:0]  dst;
        logic [63:0] data;
        logic [63:0] pc;
        logic        wr;
    } exp_t;

    exp_t ip_q[$];
    exp_t lsp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Retire monitor / scoreboard
    int   n_ret = 0;
    int   run = 0;
    int   max_run = 0;
    logic prev_ret = 1'b0;
    logic prev_lsp = 1'b0;
    logic chk_alt = 1'b0;
    logic is_lsp;
    exp_t e;

    always @(negedge clk) begin
        if (rst_n && bus.wb_retire_valid) begin
            n_ret++;
            run++;
            is_lsp = (bus.wb_retire_pc[48] == 1'b1);
            if (chk_alt && prev_ret) chk("alternate_grant", is_lsp, !prev_lsp);
            if ((is_lsp && lsp_q.size() == 0) || (!is_lsp && ip_q.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got pc %0h expected no retire", bus.wb_retire_pc);
            end else begin
                if (is_lsp) e = lsp_q.pop_front();
                else        e = ip_q.pop_front();
                chk("retire_pc", bus.wb_retire_pc, e.pc);
                chk("rf_wr_dst", bus.rf_wr_dst, e.dst);
                chk("rf_wr_data", bus.rf_wr_data, e.data);
                chk("rf_wr_en", bus.rf_wr_en, e.wr);
            end
            prev_ret = 1'b1;
            prev_lsp = is_lsp;
        end else begin
            run = 0;
            prev_ret = 1'b0;
        end
        if (run > max_run) max_run = run;
    end

    // Drivers: called #1 after a rising edge, return #1 after the accepting edge.
    task automatic send_ip(input logic [4:0] d, input logic [63:0] r, input logic [63:0] p,
                           input logic en, output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        bus.ip_wb_valid  = 1'b1;
        bus.ip_wb_dst    = d;
        bus.ip_wb_result = r;
        bus.ip_wb_pc     = p;
        bus.ip_wb_wb_en  = en;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            ok = bus.ip_wb_ready;
            @(posedge clk);
            if (ok) break;
            stalls++;
        end
        if (ok) ip_q.push_back('{dst: d, data: r, pc: p, wr: (en && d != 5'd0)});
        else begin
            checks++;
            errors++;
            $display("FAIL ip_accept_timeout: got no ready expected ready within 50 cycles");
        end
        #1;
    endtask

    task automatic send_lsp(input logic [4:0] d, input logic [63:0] r, input logic [63:0] p,
                            input logic en, output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        bus.lsp_wb_valid  = 1'b1;
        bus.lsp_wb_dst    = d;
        bus.lsp_wb_result = r;
        bus.lsp_wb_pc     = p;
        bus.lsp_wb_wb_en  = en;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            ok = bus.lsp_wb_ready;
            @(posedge clk);
            if (ok) break;
            stalls++;
        end
        if (ok) lsp_q.push_back('{dst: d, data: r, pc: p, wr: (en && d != 5'd0)});
        else begin
            checks++;
            errors++;
            $display("FAIL lsp_accept_timeout: got no ready expected ready within 50 cycles");
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s, ip_st, lsp_st, saved;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ip_wb_valid = 0; bus.ip_wb_dst = 0; bus.ip_wb_result = 0; bus.ip_wb_pc = 0; bus.ip_wb_wb_en = 0;
        bus.lsp_wb_valid = 0; bus.lsp_wb_dst = 0; bus.lsp_wb_result = 0; bus.lsp_wb_pc = 0; bus.lsp_wb_wb_en = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ip_ready", bus.ip_wb_ready, 0);
        chk("rst_lsp_ready", bus.lsp_wb_ready, 0);
        chk("rst_rf_wr_en", bus.rf_wr_en, 0);
        chk("rst_retire_valid", bus.wb_retire_valid, 0);
        chk("rst_rf_wr_dst", bus.rf_wr_dst, 0);
        chk("rst_rf_wr_data", bus.rf_wr_data, 0);
        chk("rst_retire_pc", bus.wb_retire_pc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ip_ready", bus.ip_wb_ready, 1);
        chk("rel_lsp_ready", bus.lsp_wb_ready, 1);
        @(posedge clk); #1;

        // Single ip transfer, latency and one-cycle pulse, then hold
        send_ip(5'd5, 64'h1234, 64'h8000_0000, 1'b1, s);
        bus.ip_wb_valid = 0;
        @(negedge clk);
        chk("lat_accept_cycle_wr_en", bus.rf_wr_en, 0);
        @(negedge clk);
        chk("lat_wr_en", bus.rf_wr_en, 1);
        chk("lat_retire", bus.wb_retire_valid, 1);
        chk("lat_dst", bus.rf_wr_dst, 5);
        chk("lat_data", bus.rf_wr_data, 64'h1234);
        chk("lat_pc", bus.wb_retire_pc, 64'h8000_0000);
        @(negedge clk);
        chk("pulse_wr_en_off", bus.rf_wr_en, 0);
        chk("pulse_retire_off", bus.wb_retire_valid, 0);
        chk("hold_dst", bus.rf_wr_dst, 5);
        chk("hold_data", bus.rf_wr_data, 64'h1234);
        chk("hold_pc", bus.wb_retire_pc, 64'h8000_0000);
        @(posedge clk); #1;

        // x0 write retires without rf write; wb_en=0 likewise
        send_lsp(5'd0, 64'hDEAD, LTAG | 64'h1000, 1'b1, s);
        bus.lsp_wb_valid = 0;
        idle(3);
        send_ip(5'd7, 64'h77, 64'h2000, 1'b0, s);
        bus.ip_wb_valid = 0;
        idle(3);

        // Both ports streaming: strict alternation, first contention to lsp
        max_run = 0;
        chk_alt = 1'b1;
        ip_st = 0;
        lsp_st = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send_ip(5'(k + 1), 64'h100 + 64'(k), 64'h3000 + 64'(4 * k), 1'b1, s);
                    ip_st += s;
                end
                bus.ip_wb_valid = 0;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    send_lsp(5'(k + 9), 64'h200 + 64'(k), LTAG | (64'h4000 + 64'(4 * k)), 1'b1, s);
                    lsp_st += s;
                end
                bus.lsp_wb_valid = 0;
            end
        join
        idle(4);
        chk_alt = 1'b0;
        chk("contend_run_len", 64'(max_run), 16);
        chk("ip_stall_cycles", 64'(ip_st), 7);
        chk("lsp_stall_cycles", 64'(lsp_st), 6);
        chk("contend_ip_drained", 64'(ip_q.size()), 0);
        chk("contend_lsp_drained", 64'(lsp_q.size()), 0);

        // Reset mid-cycle with both slots full
        fork
            send_ip(5'd3, 64'hAAA, 64'h5000, 1'b1, s);
            send_lsp(5'd4, 64'hBBB, LTAG | 64'h6000, 1'b1, s);
        join
        bus.ip_wb_valid = 0;
        bus.lsp_wb_valid = 0;
        #2 rst_n = 1'b0;
        ip_q.delete();
        lsp_q.delete();
        #1;
        chk("midrst_rf_wr_en", bus.rf_wr_en, 0);
        chk("midrst_retire", bus.wb_retire_valid, 0);
        chk("midrst_dst", bus.rf_wr_dst, 0);
        chk("midrst_data", bus.rf_wr_data, 0);
        chk("midrst_pc", bus.wb_retire_pc, 0);
        chk("midrst_ip_ready", bus.ip_wb_ready, 0);
        chk("midrst_lsp_ready", bus.lsp_wb_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saved = n_ret;
        idle(4);
        chk("no_retire_after_rst", 64'(n_ret), 64'(saved));

        send_ip(5'd9, 64'h999, 64'h7000, 1'b1, s);
        bus.ip_wb_valid = 0;
        @(negedge clk);
        chk("post_rst_accept_wr_en", bus.rf_wr_en, 0);
        @(negedge clk);
        chk("post_rst_wr_en", bus.rf_wr_en, 1);
        chk("post_rst_dst", bus.rf_wr_dst, 9);
        @(posedge clk); #1;
        idle(2);

`ifdef WB_ARB_PERF_EN
        for (int k = 0; k < 4; k++) begin
            send_lsp(5'(k + 20), 64'h500 + 64'(k), LTAG | (64'h8000 + 64'(k)), 1'b1, s);
            bus.lsp_wb_valid = 0;
            idle(2);
        end
        idle(2);
        chk("perf_count_5", cnt, 5);
        force dut.retired_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.retired_cnt_q;
        chk("perf_preset", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        send_ip(5'd1, 64'h1, 64'h9000, 1'b1, s);
        bus.ip_wb_valid = 0;
        idle(4);
        chk("perf_wrap", cnt, 0);
`endif

        idle(3);
        chk("final_ip_empty", 64'(ip_q.size()), 0);
        chk("final_lsp_empty", 64'(lsp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
